bw_iodll_ctl: RTL

//  Parametrised digital master-DLL loop controller, next generation of the DDR master DLL.

---
 rtl/bw_iodll_ctl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bw_iodll_ctl.sv
// Master-DLL loop controller: filters early/late phase-detector votes into a saturating
// delay code, applies a signed trim, and manages lock, bypass and test-freeze modes.
module bw_iodll_ctl #(
    parameter int CODE_W    = 5,
    parameter int TRIM_W    = 3,
    parameter int FILT_TH   = 4,
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_CNT  = 4,
    parameter int INIT_CODE = 16
) (
    input  logic              ddr_clk_in,
    input  logic              io_dll_reset_l,
    input  logic              pd_early,
    input  logic              pd_late,
    input  logic [TRIM_W-1:0] delay_ctrl,
    input  logic              io_dll_bypass_l,
    input  logic [CODE_W-1:0] bypass_data,
    input  logic              ddr_testmode_l,
    output logic              iodll_lock,
    output logic [CODE_W-1:0] lpf_out,
    output logic              strobe,
    output logic              overflow,
    output logic              underflow,
    output logic [1:0]        o_dbg_state
);
    localparam int ACC_W = $clog2(FILT_TH) + 2;
    localparam int REV_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(LOSS_CNT + 1);
    localparam logic [CODE_W-1:0]       CODE_MAX = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0]       CODE_INI = CODE_W'(INIT_CODE);
    localparam logic signed [ACC_W-1:0] TH_P     = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_N     = -TH_P;
    localparam logic [REV_W-1:0]        REV_MAX  = REV_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]        RUN_MAX  = RUN_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        S_ACQ    = 2'd0,
        S_TRACK  = 2'd1,
        S_BYPASS = 2'd2,
        S_FREEZE = 2'd3
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc, w_acc_sum, w_acc_nxt;
    logic [CODE_W-1:0]        r_code, w_code_nxt;
    logic [CODE_W-1:0]        r_lpf, w_lpf_nxt;
    logic [REV_W-1:0]         r_rev, w_rev_nxt;
    logic [RUN_W-1:0]         r_run, w_run_nxt;
    logic                     r_lock, w_lock_nxt;
    logic                     r_strobe, r_ovf, r_udf;
    logic                     r_have_prev, r_prev_up, r_frz_track;
    logic                     w_loop, w_step_up, w_step_dn, w_step;

    // Clamp code + sign-extended trim into the legal code range.
    function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] c,
                                                  input logic [TRIM_W-1:0] t);
        logic signed [CODE_W+1:0] sum;
        sum = $signed({2'b00, c}) + $signed({{(CODE_W+2-TRIM_W){t[TRIM_W-1]}}, t});
        if (sum < 0)                           return '0;
        else if (sum > $signed({2'b00, CODE_MAX})) return CODE_MAX;
        else                                   return sum[CODE_W-1:0];
    endfunction

    assign w_loop = io_dll_bypass_l && ddr_testmode_l && (r_state == S_ACQ || r_state == S_TRACK);

    always_comb begin
        w_acc_sum   = r_acc;
        w_acc_nxt   = r_acc;
        w_code_nxt  = r_code;
        w_rev_nxt   = r_rev;
        w_run_nxt   = r_run;
        w_state_nxt = r_state;
        if (pd_early && !pd_late)      w_acc_sum = r_acc + ACC_W'(1);
        else if (pd_late && !pd_early) w_acc_sum = r_acc - ACC_W'(1);
        w_step_up = w_loop && (w_acc_sum == TH_P);
        w_step_dn = w_loop && (w_acc_sum == TH_N);
        w_step    = w_step_up || w_step_dn;

        if (w_loop) w_acc_nxt = w_step ? '0 : w_acc_sum;
        if (w_step_up && r_code != CODE_MAX) w_code_nxt = r_code + CODE_W'(1);
        if (w_step_dn && r_code != '0)       w_code_nxt = r_code - CODE_W'(1);

        // A held (saturated) step still counts in its requested direction.
        if (w_step) begin
            if (r_have_prev && (r_prev_up != w_step_up)) begin
                w_rev_nxt = (r_rev == REV_MAX) ? r_rev : r_rev + REV_W'(1);
                w_run_nxt = RUN_W'(1);
            end else begin
                w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
                w_rev_nxt = '0;
            end
        end

        if (!io_dll_bypass_l) begin
            w_state_nxt = S_BYPASS;
            w_acc_nxt   = '0;
            w_rev_nxt   = '0;
            w_run_nxt   = '0;
        end else begin
            case (r_state)
                S_BYPASS: w_state_nxt = S_ACQ;
                S_FREEZE: if (ddr_testmode_l) w_state_nxt = r_frz_track ? S_TRACK : S_ACQ;
                S_ACQ:
                    if (!ddr_testmode_l)                    w_state_nxt = S_FREEZE;
                    else if (w_step && w_rev_nxt == REV_MAX) w_state_nxt = S_TRACK;
                S_TRACK:
                    if (!ddr_testmode_l)                    w_state_nxt = S_FREEZE;
                    else if (w_step && w_run_nxt == RUN_MAX) w_state_nxt = S_ACQ;
                default: w_state_nxt = S_ACQ;
            endcase
        end
        w_lock_nxt = (w_state_nxt == S_TRACK) || (w_state_nxt == S_FREEZE && r_lock);
        w_lpf_nxt  = io_dll_bypass_l ? sat_add(r_code, delay_ctrl) : bypass_data;
    end

    always_ff @(posedge ddr_clk_in) begin
        if (!io_dll_reset_l) begin
            r_state     <= S_ACQ;
            r_acc       <= '0;
            r_code      <= CODE_INI;
            r_rev       <= '0;
            r_run       <= '0;
            r_lock      <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_strobe    <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_up   <= 1'b0;
            r_frz_track <= 1'b0;
            r_lpf       <= io_dll_bypass_l ? sat_add(CODE_INI, delay_ctrl) : bypass_data;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_code   <= w_code_nxt;
            r_rev    <= w_rev_nxt;
            r_run    <= w_run_nxt;
            r_lock   <= w_lock_nxt;
            r_ovf    <= r_ovf | (w_step_up && r_code == CODE_MAX);
            r_udf    <= r_udf | (w_step_dn && r_code == '0);
            r_lpf    <= w_lpf_nxt;
            r_strobe <= (w_lpf_nxt != r_lpf);
            if (w_step) begin
                r_have_prev <= 1'b1;
                r_prev_up   <= w_step_up;
            end
            if (w_state_nxt == S_FREEZE && r_state != S_FREEZE)
                r_frz_track <= (r_state == S_TRACK);
        end
    end

    assign iodll_lock  = r_lock;
    assign lpf_out     = r_lpf;
    assign strobe      = r_strobe;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
    assign o_dbg_state = r_state;
endmodule
